// File: rtl/alu_result_stage.sv
// EX->WB boundary behind the integer ALU: 2-entry skid buffer with
// valid/ready on both sides and a sticky overflow bit for the status register.
module alu_result_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic                      in_n,
    input  logic                      in_v,
    input  logic                      in_z,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_we,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic                      out_n,
    output logic                      out_v,
    output logic                      out_z,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_we,
    input  logic                      clr_sticky,
    output logic                      sticky_v
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic                      n;
        logic                      v;
        logic                      z;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_e;
    logic   main_vld;
    logic   skid_vld;
    logic   accept;
    logic   commit;
    state_t state;

    assign in_e     = '{result: in_result, n: in_n, v: in_v,
                        z: in_z, rd: in_rd, we: in_we};
    assign state    = state_t'({main_vld, skid_vld});
    assign in_ready = ~skid_vld;
    assign accept   = in_valid & in_ready;
    assign commit   = main_vld & out_ready;

    assign out_valid  = main_vld;
    assign out_result = main_q.result;
    assign out_n      = main_q.n;
    assign out_v      = main_q.v;
    assign out_z      = main_q.z;
    assign out_rd     = main_q.rd;
    assign out_we     = main_q.we & main_vld;

    // Buffer occupancy and payload movement; flush only drops valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q   <= in_e;
                        main_vld <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && commit) begin
                        main_q <= in_e;
                    end else if (accept) begin
                        skid_q   <= in_e;
                        skid_vld <= 1'b1;
                    end else if (commit) begin
                        main_vld <= 1'b0;
                    end
                end
                FULL: begin
                    if (commit) begin
                        main_q   <= skid_q;
                        skid_vld <= 1'b0;
                    end
                end
                default: begin
                    main_vld <= 1'b0;
                    skid_vld <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: any committed V sets it, set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_v <= 1'b0;
        end else if (commit && main_q.v) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end
    end

endmodule
